sram64kb_ctrl: RTL and testbench

Sequencing controller directly upstream of the 64 KB banked SRAM (64 banks × 1024 × 8). It accepts single-byte read/write requests on a valid/ready port. It decodes the 16-bit byte address into a 6-bit bank and a 10-bit word, and drives the array's one-hot active-low bank selects, output enables, write strobe and CE pulse. Read data is captured from the array and returned on a one-cycle response strobe.

---
 rtl/sram64kb_pkg.sv | 22 ++
 rtl/sram64kb_ctrl_if.sv | 24 ++
 rtl/sram64kb_bank_dec.sv | 18 +
 rtl/sram64kb_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram64kb_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram64kb_pkg.sv
// Shared constants and FSM state encoding for the 64 KB banked SRAM controller.
package sram64kb_pkg;

    localparam int NUM_BANKS = 64;
    localparam int BANK_W    = 6;
    localparam int WORD_W    = 10;
    localparam int DATA_W    = 8;
    localparam int ST_W      = 3;

    typedef logic [ST_W-1:0] state_t;

    // Verify states only reachable when SRAM_CTRL_WVERIFY_EN is defined.
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_STROBE  = 3'd2;
    localparam state_t ST_CAPT    = 3'd3;
    localparam state_t ST_RESP    = 3'd4;
    localparam state_t ST_VSETUP  = 3'd5;
    localparam state_t ST_VSTROBE = 3'd6;
    localparam state_t ST_VCAPT   = 3'd7;

endpackage

// File: rtl/sram64kb_ctrl_if.sv
// Request/response port of the SRAM controller: valid/ready request, one-cycle response strobe.
interface sram64kb_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram64kb_bank_dec.sv
// Bank index to active-low one-hot select; all ones when disabled.
module sram64kb_bank_dec
    import sram64kb_pkg::*;
#(
    parameter int NB = NUM_BANKS,
    parameter int BW = BANK_W
) (
    input  logic [BW-1:0] bank,
    input  logic          en,
    output logic [NB-1:0] sel_b
);

    always_comb begin
        sel_b = '1;
        if (en) sel_b[bank] = 1'b0;
    end

endmodule

// File: rtl/sram64kb_ctrl.sv
// Sequencing controller for the 64 x 1024 x 8 banked SRAM.
// Optional write read-back verify: define SRAM_CTRL_WVERIFY_EN.
//
// state    | meaning
// IDLE     | ready, array deselected
// SETUP    | address, selects, WEB/OEB driven
// STROBE   | one-cycle CE pulse
// CAPT     | CE low; read data sampled from ODATA
// RESP     | response strobe; ready for the next request
// VSETUP   | (verify) write target re-enabled for read
// VSTROBE  | (verify) CE pulse for read-back
// VCAPT    | (verify) read-back compared with written data
module sram64kb_ctrl
    import sram64kb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int NUM_BANKS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram64kb_ctrl_if.slave       bus,
    output logic [WORD_W-1:0]    mem_addr,
    output logic                 mem_ce,
    output logic                 mem_web,
    output logic [NUM_BANKS-1:0] mem_oeb,
    output logic [NUM_BANKS-1:0] mem_csb,
    output logic [DATA_W-1:0]    mem_idata,
    input  logic [DATA_W-1:0]    odata
);

    state_t              state;
    logic                wr_q;
    logic [BANK_W-1:0]   bank_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                accept;
    logic [BANK_W-1:0]   req_bank;
    logic [BANK_W-1:0]   dec_bank;
    logic                oeb_en;
    logic [NUM_BANKS-1:0] csb_nxt;
    logic [NUM_BANKS-1:0] oeb_nxt;

    assign bus.req_ready = (state == ST_IDLE) || (state == ST_RESP);
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_bank      = bus.req_addr[ADDR_W-1 -: BANK_W];
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Decoders see the incoming request on accept, otherwise the latched bank (verify read-back).
    assign dec_bank = accept ? req_bank : bank_q;
    assign oeb_en   = accept ? ~bus.req_wr : 1'b1;

    sram64kb_bank_dec #(.NB(NUM_BANKS), .BW(BANK_W)) u_csb_dec (
        .bank  (dec_bank),
        .en    (1'b1),
        .sel_b (csb_nxt)
    );

    sram64kb_bank_dec #(.NB(NUM_BANKS), .BW(BANK_W)) u_oeb_dec (
        .bank  (dec_bank),
        .en    (oeb_en),
        .sel_b (oeb_nxt)
    );

`ifdef SRAM_CTRL_WVERIFY_EN
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_q        <= 1'b0;
            bank_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr    <= '0;
            mem_ce      <= 1'b0;
            mem_web     <= 1'b1;
            mem_oeb     <= '1;
            mem_csb     <= '1;
            mem_idata   <= '0;
`ifdef SRAM_CTRL_WVERIFY_EN
            wdata_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    rsp_valid_q <= 1'b0;
`ifdef SRAM_CTRL_WVERIFY_EN
                    err_q       <= 1'b0;
`endif
                    if (accept) begin
                        state    <= ST_SETUP;
                        wr_q     <= bus.req_wr;
                        bank_q   <= req_bank;
                        mem_addr <= bus.req_addr[WORD_W-1:0];
                        mem_csb  <= csb_nxt;
                        mem_oeb  <= oeb_nxt;
                        mem_web  <= ~bus.req_wr;
                        if (bus.req_wr) mem_idata <= bus.req_wdata;
`ifdef SRAM_CTRL_WVERIFY_EN
                        wdata_q  <= bus.req_wdata;
`endif
                    end else begin
                        state   <= ST_IDLE;
                        mem_csb <= '1;
                        mem_oeb <= '1;
                    end
                end
                ST_SETUP: begin
                    mem_ce <= 1'b1;
                    state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    mem_ce  <= 1'b0;
                    mem_web <= 1'b1;
                    state   <= ST_CAPT;
                end
                ST_CAPT: begin
                    rsp_rdata_q <= wr_q ? '0 : odata;
`ifdef SRAM_CTRL_WVERIFY_EN
                    if (wr_q) begin
                        mem_oeb <= oeb_nxt;
                        state   <= ST_VSETUP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
`else
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
`endif
                end
`ifdef SRAM_CTRL_WVERIFY_EN
                ST_VSETUP: begin
                    mem_ce <= 1'b1;
                    state  <= ST_VSTROBE;
                end
                ST_VSTROBE: begin
                    mem_ce <= 1'b0;
                    state  <= ST_VCAPT;
                end
                ST_VCAPT: begin
                    rsp_rdata_q <= odata;
                    err_q       <= (odata != wdata_q);
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram64kb_ctrl.sv
// Directed bench for sram64kb_ctrl with a behavioural 64-bank array model.
module tb_sram64kb_ctrl;
    import sram64kb_pkg::*;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  mem_addr;
    logic        mem_ce;
    logic        mem_web;
    logic [63:0] mem_oeb;
    logic [63:0] mem_csb;
    logic [7:0]  mem_idata;
    logic [7:0]  odata;

    logic [7:0]  arr [0:65535];
    logic [7:0]  rd_q = 8'h00;
    logic        stuck0 = 1'b0;
    int          overlap = 0;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs [8];
    logic [15:0] ba [3];
    logic [7:0]  bd [3];

    always #5 clk = ~clk;

    sram64kb_ctrl_if bus ();

    sram64kb_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_ce    (mem_ce),
        .mem_web   (mem_web),
        .mem_oeb   (mem_oeb),
        .mem_csb   (mem_csb),
        .mem_idata (mem_idata),
        .odata     (odata)
    );

    function automatic int find_bank(input logic [63:0] v);
        int r;
        r = -1;
        for (int i = 63; i >= 0; i--) if (!v[i]) r = i;
        return r;
    endfunction

    // Array model: synchronous on CE, read data held until next read, OR-merged under OEB.
    always @(posedge clk) begin
        int          b;
        logic [15:0] idx;
        if (mem_ce) begin
            b = find_bank(mem_csb);
            if (b >= 0) begin
                idx = {b[5:0], mem_addr};
                if (!mem_web) arr[idx] <= mem_idata & (stuck0 ? 8'hFE : 8'hFF);
                else          rd_q     <= arr[idx];
            end
        end
    end
    assign odata = (&mem_oeb) ? 8'h00 : rd_q;

    always @(negedge clk) begin
        if ($countones(~mem_csb) > 1 || $countones(~mem_oeb) > 1) overlap++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        int          lat;
        logic [63:0] onehot;
        onehot = ~(64'd1 << v.addr[15:10]);
        lat = 4;
`ifdef SRAM_CTRL_WVERIFY_EN
        if (v.wr) lat = 7;
`endif
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        chk("ready_idle", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("setup_csb", mem_csb, onehot);
        chk("setup_oeb", mem_oeb, v.wr ? {64{1'b1}} : onehot);
        chk("setup_addr", mem_addr, v.addr[9:0]);
        chk("setup_web", mem_web, !v.wr);
        if (v.wr) chk("setup_idata", mem_idata, v.wdata);
        chk("setup_ce", mem_ce, 0);
        chk("setup_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("strobe_ce", mem_ce, 1);
        chk("strobe_csb", mem_csb, onehot);
        for (int k = 3; k < lat; k++) begin
            @(posedge clk); #1;
            chk("early_rsp", bus.rsp_valid, 0);
            if (k == 3) begin
                chk("capt_ce", mem_ce, 0);
                chk("capt_web", mem_web, 1);
            end
        end
        @(posedge clk); #1;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
        chk("rsp_err", bus.rsp_err, v.exp_err);
        @(posedge clk); #1;
        chk("rsp_one_cycle", bus.rsp_valid, 0);
        chk("idle_csb", mem_csb, {64{1'b1}});
        chk("idle_oeb", mem_oeb, {64{1'b1}});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.req_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_ce"}, mem_ce, 0);
        chk({tag, "_mem_web"}, mem_web, 1);
        chk({tag, "_mem_idata"}, mem_idata, 0);
        chk({tag, "_mem_oeb"}, mem_oeb, {64{1'b1}});
        chk({tag, "_mem_csb"}, mem_csb, {64{1'b1}});
    endtask

    function automatic logic [7:0] wr_rsp(input logic [7:0] d);
`ifdef SRAM_CTRL_WVERIFY_EN
        return d;
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        int seen;
        for (int i = 0; i < 65536; i++) arr[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        vecs[0] = '{1'b1, 16'h0000, 8'hA5, wr_rsp(8'hA5), 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 8'h00, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 16'h03FF, 8'h11, wr_rsp(8'h11), 1'b0};
        vecs[3] = '{1'b1, 16'h0400, 8'h22, wr_rsp(8'h22), 1'b0};
        vecs[4] = '{1'b0, 16'h03FF, 8'h00, 8'h11, 1'b0};
        vecs[5] = '{1'b0, 16'h0400, 8'h00, 8'h22, 1'b0};
        vecs[6] = '{1'b1, 16'hFFFF, 8'h5A, wr_rsp(8'h5A), 1'b0};
        vecs[7] = '{1'b0, 16'hFFFF, 8'h00, 8'h5A, 1'b0};
        ba[0] = 16'h0000; ba[1] = 16'h03FF; ba[2] = 16'h0400;
        bd[0] = 8'hA5;    bd[1] = 8'h11;    bd[2] = 8'h22;

        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) do_req(vecs[i]);

        // Back-to-back reads with REQ_VALID held; each RESP cycle is also the next accept.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = ba[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) bus.req_addr = ba[i+1];
            else       bus.req_valid = 1'b0;
            chk("b2b_csb", mem_csb, ~(64'd1 << ba[i][15:10]));
            chk("b2b_ready_setup", bus.req_ready, 0);
            @(posedge clk); #1;
            chk("b2b_ready_strobe", bus.req_ready, 0);
            @(posedge clk); #1;
            chk("b2b_ready_capt", bus.req_ready, 0);
            chk("b2b_early_rsp", bus.rsp_valid, 0);
            @(posedge clk); #1;
            chk("b2b_rsp_valid", bus.rsp_valid, 1);
            chk("b2b_rsp_rdata", bus.rsp_rdata, bd[i]);
            chk("b2b_ready_resp", bus.req_ready, 1);
        end
        @(posedge clk); #1;
        chk("b2b_tail_rsp", bus.rsp_valid, 0);
        chk("b2b_tail_csb", mem_csb, {64{1'b1}});

        // Reset during STROBE aborts the write with no response.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 16'h1234;
        bus.req_wdata = 8'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_strobe_ce", mem_ce, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        do_req('{1'b0, 16'h1234, 8'h00, 8'h00, 1'b0});

        // Reset while idle with non-zero read data held on the response port.
        do_req(vecs[7]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("idle_rst");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SRAM_CTRL_WVERIFY_EN
        stuck0 = 1'b1;
        do_req('{1'b1, 16'h0010, 8'h01, 8'h00, 1'b1});
        stuck0 = 1'b0;
`endif

        chk("csb_oeb_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
